// File: rtl/led_pkg.sv
// Shared constants for the seven-segment scanner: active-high segment
// patterns ordered {a,b,c,d,e,f,g} and the digit-index width helper.
package led_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b0011111;
  localparam logic [6:0] SEG_C     = 7'b1001110;
  localparam logic [6:0] SEG_D     = 7'b0111101;
  localparam logic [6:0] SEG_E     = 7'b1001111;
  localparam logic [6:0] SEG_F     = 7'b1000111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Never returns less than 1 so a two-digit scanner still gets a real index bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/hex_seg_decoder.sv
// Combinational hex nibble to active-high seven-segment pattern.
module hex_seg_decoder
  import led_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (hex)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/multi_digit_led_scanner.sv
// Time-multiplexed common-anode seven-segment scanner with prescaled refresh,
// frame-aligned (tear-free) data loading, blanking and leading-zero suppression.
module multi_digit_led_scanner
  import led_pkg::*;
#(
  parameter int                    NUM_DIGITS       = 4,
  parameter int                    PRESCALE_W       = 16,
  parameter logic [PRESCALE_W-1:0] DEFAULT_PRESCALE = 16'd50000,
  parameter bit                    ACTIVE_LOW       = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_suppress,
  input  logic [PRESCALE_W-1:0]   prescale,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    scan_tick,
  output logic                    frame_done
);

  localparam int                    IDX_W    = clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{ACTIVE_LOW}};
  localparam logic [6:0]            SEG_OFF  = {7{ACTIVE_LOW}};

  logic [PRESCALE_W-1:0]   count_q, count_d;
  logic [PRESCALE_W-1:0]   period_q, period_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    scan_tick_q, scan_tick_d;
  logic                    frame_done_q, frame_done_d;
  logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;
  logic [4*NUM_DIGITS-1:0] shadow_data_q, shadow_data_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [NUM_DIGITS-1:0]   shadow_blank_q, shadow_blank_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;

  logic                    tick, wrap;
  logic [3:0]              nibble;
  logic [6:0]              seg_raw;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    zero_run;
  logic                    digit_blank;
  logic [NUM_DIGITS-1:0]   onehot;

  // The period is registered so a prescale change takes effect one cycle later;
  // the reset value holds off the first tick until a real period is seen.
  always_comb begin
    period_d     = prescale;
    tick         = (count_q == period_q);
    wrap         = tick && (idx_q == LAST_IDX);
    count_d      = tick ? '0 : count_q + PRESCALE_W'(1);
    idx_d        = idx_q;
    if (tick) idx_d = wrap ? '0 : idx_q + IDX_W'(1);
    scan_tick_d  = tick;
    frame_done_d = wrap;
  end

  // pend_*_d already carries a coincident load, so the wrap copy picks it up directly.
  always_comb begin
    pend_data_d    = load ? data_in  : pend_data_q;
    pend_dp_d      = load ? dp_in    : pend_dp_q;
    pend_blank_d   = load ? blank_in : pend_blank_q;
    shadow_data_d  = shadow_data_q;
    shadow_dp_d    = shadow_dp_q;
    shadow_blank_d = shadow_blank_q;
    if (wrap) begin
      shadow_data_d  = pend_data_d;
      shadow_dp_d    = pend_dp_d;
      shadow_blank_d = pend_blank_d;
    end
  end

  // A digit is a leading zero when it and every digit above it hold zero.
  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run && (shadow_data_q[4*i +: 4] == 4'h0);
      lz_mask[i] = zero_run;
    end
  end

  assign nibble = shadow_data_q[{idx_q, 2'b00} +: 4];

  hex_seg_decoder u_dec (
    .hex (nibble),
    .seg (seg_raw)
  );

  always_comb begin
    digit_blank = shadow_blank_q[idx_q] | (lz_suppress & lz_mask[idx_q]);
    onehot      = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q;
    an_d        = AN_OFF;
    seg_d       = SEG_OFF;
    dp_d        = ACTIVE_LOW;
    if (!digit_blank) begin
      an_d  = onehot ^ {NUM_DIGITS{ACTIVE_LOW}};
      seg_d = seg_raw ^ {7{ACTIVE_LOW}};
      dp_d  = shadow_dp_q[idx_q] ^ ACTIVE_LOW;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q        <= '0;
      period_q       <= DEFAULT_PRESCALE;
      idx_q          <= '0;
      scan_tick_q    <= 1'b0;
      frame_done_q   <= 1'b0;
      pend_data_q    <= '0;
      pend_dp_q      <= '0;
      pend_blank_q   <= '0;
      shadow_data_q  <= '0;
      shadow_dp_q    <= '0;
      shadow_blank_q <= '0;
      an_q           <= AN_OFF;
      seg_q          <= SEG_OFF;
      dp_q           <= ACTIVE_LOW;
    end else begin
      count_q        <= count_d;
      period_q       <= period_d;
      idx_q          <= idx_d;
      scan_tick_q    <= scan_tick_d;
      frame_done_q   <= frame_done_d;
      pend_data_q    <= pend_data_d;
      pend_dp_q      <= pend_dp_d;
      pend_blank_q   <= pend_blank_d;
      shadow_data_q  <= shadow_data_d;
      shadow_dp_q    <= shadow_dp_d;
      shadow_blank_q <= shadow_blank_d;
      an_q           <= an_d;
      seg_q          <= seg_d;
      dp_q           <= dp_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign scan_tick  = scan_tick_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_multi_digit_led_scanner.sv
// Self-checking bench: directed and random stimulus compared every cycle
// against a frame-level behavioural model of the scanner (4 digits, active-low).
module tb_multi_digit_led_scanner;

  localparam int N = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          load = 1'b0;
  logic [15:0]   data_in = '0;
  logic [3:0]    dp_in = '0;
  logic [3:0]    blank_in = '0;
  logic          lz_suppress = 1'b0;
  logic [15:0]   prescale = 16'd3;
  logic [3:0]    an;
  logic [6:0]    seg;
  logic          dp;
  logic          scan_tick;
  logic          frame_done;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  int          m_cnt = 0;
  int          m_idx = 0;
  logic [15:0] m_pend_data = '0, m_sh_data = '0;
  logic [3:0]  m_pend_dp = '0, m_sh_dp = '0;
  logic [3:0]  m_pend_blank = '0, m_sh_blank = '0;
  logic [3:0]  e_an = 4'b1111;
  logic [6:0]  e_seg = 7'b1111111;
  logic        e_dp = 1'b1, e_tick = 1'b0, e_fd = 1'b0;

  // Active-high {a..g} glyphs for 0-F
  logic [6:0] hex_ref [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  multi_digit_led_scanner #(
    .NUM_DIGITS       (N),
    .PRESCALE_W       (16),
    .DEFAULT_PRESCALE (16'd50000),
    .ACTIVE_LOW       (1'b1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .load        (load),
    .data_in     (data_in),
    .dp_in       (dp_in),
    .blank_in    (blank_in),
    .lz_suppress (lz_suppress),
    .prescale    (prescale),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .scan_tick   (scan_tick),
    .frame_done  (frame_done)
  );

  always #5 clock = ~clock;

  // One clock edge of the model: the display shows the digit selected before the
  // edge; a tick every prescale+1 cycles steps the digit; the frame's last tick
  // latches the most recent load (including one in the same cycle).
  task automatic modelStep();
    logic blk;
    logic tick;
    if (reset) begin
      m_cnt = 0; m_idx = 0;
      m_pend_data = '0; m_pend_dp = '0; m_pend_blank = '0;
      m_sh_data = '0; m_sh_dp = '0; m_sh_blank = '0;
      e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1; e_tick = 1'b0; e_fd = 1'b0;
    end else begin
      blk = m_sh_blank[m_idx] || (lz_suppress && m_idx != 0 && ((m_sh_data >> (4 * m_idx)) == 16'h0));
      if (blk) begin
        e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1;
      end else begin
        e_an  = ~(4'b0001 << m_idx);
        e_seg = ~hex_ref[(m_sh_data >> (4 * m_idx)) & 16'hF];
        e_dp  = ~m_sh_dp[m_idx];
      end
      tick   = (m_cnt == int'(prescale));
      e_tick = tick;
      e_fd   = tick && (m_idx == N - 1);
      if (e_fd) begin
        m_sh_data  = load ? data_in  : m_pend_data;
        m_sh_dp    = load ? dp_in    : m_pend_dp;
        m_sh_blank = load ? blank_in : m_pend_blank;
      end
      if (load) begin
        m_pend_data = data_in; m_pend_dp = dp_in; m_pend_blank = blank_in;
      end
      m_cnt = tick ? 0 : m_cnt + 1;
      m_idx = tick ? (m_idx + 1) % N : m_idx;
    end
  endtask

  task automatic checkOutput();
    tests_run++;
    assert (an === e_an) else begin
      tests_failed++; $error("[TB] FAIL an: observed %b expected %b", an, e_an);
    end
    tests_run++;
    assert (seg === e_seg) else begin
      tests_failed++; $error("[TB] FAIL seg: observed %b expected %b (an=%b)", seg, e_seg, an);
    end
    tests_run++;
    assert (dp === e_dp) else begin
      tests_failed++; $error("[TB] FAIL dp: observed %b expected %b", dp, e_dp);
    end
    tests_run++;
    assert (scan_tick === e_tick) else begin
      tests_failed++; $error("[TB] FAIL scan_tick: observed %b expected %b", scan_tick, e_tick);
    end
    tests_run++;
    assert (frame_done === e_fd) else begin
      tests_failed++; $error("[TB] FAIL frame_done: observed %b expected %b", frame_done, e_fd);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic ld, input logic lz,
                               input logic [15:0] d, input logic [3:0] dpv,
                               input logic [3:0] bl);
    reset = rst; load = ld; lz_suppress = lz;
    data_in = d; dp_in = dpv; blank_in = bl;
    @(posedge clock);
    modelStep();
    @(negedge clock);
    checkOutput();
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'b0, lz_suppress, data_in, dp_in, blank_in);
  endtask

  // Idle until the model's next edge is the frame-wrap tick; expired bound is a failure.
  task automatic waitForWrap();
    int guard;
    guard = 0;
    while (!(m_cnt == int'(prescale) && m_idx == N - 1) && guard < 200) begin
      runCycles(1);
      guard++;
    end
    tests_run++;
    assert (guard < 200) else begin
      tests_failed++; $error("[TB] FAIL wrap_wait: observed %0d cycles expected <200", guard);
    end
  endtask

  function automatic logic [15:0] sparseWord();
    logic [15:0] w;
    w = 16'($urandom);
    for (int k = 0; k < 4; k++)
      if ($urandom_range(1) == 0) w[4*k +: 4] = 4'h0;
    return w;
  endfunction

  initial begin
    // Reset held, then basic scan at prescale=3
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
    runCycles(40);

    // Mid-frame load of 12AF
    while (m_idx != 1) runCycles(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h12AF, 4'h0, 4'h0);
    runCycles(40);

    // Leading-zero suppression
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0050, 4'h0, 4'h0);
    runCycles(40);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0000, 4'h0, 4'h0);
    runCycles(40);

    // Decimal point on digit 2, digit 0 forced dark
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h3456, 4'b0100, 4'b0001);
    runCycles(40);

    // Load coincident with the wrap tick, second load two cycles later
    waitForWrap();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'hBEEF, 4'b0011, 4'b0000);
    runCycles(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'hC0DE, 4'b1000, 4'b0000);
    runCycles(50);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b0, ($urandom_range(7) == 0), ($urandom_range(15) == 0) ? ~lz_suppress : lz_suppress,
                    sparseWord(), 4'($urandom_range(15)),
                    ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'h0);
    end

    // Reset mid-scan with a pending load outstanding
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h9876, 4'hF, 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h9876, 4'hF, 4'h0);
    runCycles(1);
    reset = 1'b0;
    runCycles(30);

    // New prescale chosen under reset, then more random traffic
    for (int r = 0; r < 2; r++) begin
      prescale = 16'($urandom_range(4, 1));
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
      for (int i = 0; i < 200; i++) begin
        applyStimulus(1'b0, ($urandom_range(5) == 0), ($urandom_range(1) == 0),
                      sparseWord(), 4'($urandom_range(15)),
                      ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'h0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/multi_digit_led_scanner.md
Name: multi_digit_led_scanner

Overview:
Parametrised successor to the team's fixed four-digit display driver. Time-multiplexes NUM_DIGITS common-anode seven-segment digits from a packed hex data word. Adds a programmable refresh prescaler, per-digit blanking, decimal points, leading-zero suppression and a load handshake that makes digit updates tear-free. Sits between the counter/datapath logic and the board's anode/cathode pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
PRESCALE_W, 16, width of refresh prescaler counter
DEFAULT_PRESCALE, 16'd50000, reload value applied at reset
ACTIVE_LOW, 1, 1 = anodes and segments driven low-active

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
load  in  1  one-cycle strobe: capture data_in, dp_in and blank_in
data_in  in  4*NUM_DIGITS  hex nibbles; digit 0 = bits [3:0] (rightmost)
dp_in  in  NUM_DIGITS  decimal point per digit
blank_in  in  NUM_DIGITS  force digit dark
lz_suppress  in  1  blank leading zero digits (level, sampled live)
prescale  in  PRESCALE_W  tick period minus 1; 0 = tick every cycle
an  out  NUM_DIGITS  anode enables, one-hot (per ACTIVE_LOW)
seg  out  7  segments {a,b,c,d,e,f,g}, a = MSB
dp  out  1  decimal point segment
scan_tick  out  1  one-cycle pulse on each digit advance
frame_done  out  1  one-cycle pulse when digit NUM_DIGITS-1 hands over to digit 0

Behaviour:
- Reset: prescaler = 0; digit index = 0; shadow data, dp and blank registers = 0; an = all inactive; seg and dp inactive; scan_tick = 0; frame_done = 0.
- Prescaler: counts up each cycle. When count == prescale, it clears and asserts an internal tick for one cycle. If prescale changes below the current count, the next compare runs on wrap-around.
- Scan: on each tick, the index advances index+1, wrapping from NUM_DIGITS-1 to 0. scan_tick mirrors the tick, registered, so it lags the tick by 1 cycle.
- frame_done: pulses in the same cycle as the scan_tick whose new index is 0.
- Load: on load=1, data_in, dp_in and blank_in go to pending registers. The pending registers are copied to the shadow registers on the next tick that wraps the index to 0. Display frames therefore never mix old and new data.
  - If load and the wrap tick occur in the same cycle, the new value goes straight to the shadow registers.
  - Multiple loads within a frame: the last one wins.
- Output stage: fully registered, 1-cycle latency from index change. an, seg and dp all update together, so there is no ghosting skew.
- Blanking: a digit is blanked if its blank bit is set, or if lz_suppress=1, its nibble is 0, and all higher-index nibbles are 0.
  - Digit 0 is never suppressed by lz_suppress.
  - A blanked digit's an stays inactive. seg and dp are driven inactive.
- Decoder: 0-F hex, standard patterns, active-high internally. Polarity is inverted at the output if ACTIVE_LOW=1.
- Reset mid-frame: everything returns to reset values in the next cycle. Pending loads are lost.

Decomposition:
- Shared package led_pkg holds:
  - the 7-bit segment pattern constants SEG_0..SEG_F
  - the SEG_BLANK constant
  - the digit index width function clog2(NUM_DIGITS)
- One sub-module, hex_seg_decoder: purely combinational, 4-bit in, 7-bit out, instantiated once after the digit mux.

Test Plan:
- Reset, then release with prescale=3, NUM_DIGITS=4, ACTIVE_LOW=1 -> scan_tick every 4 cycles; an sequences 1110,1101,1011,0111; frame_done once every 16 cycles.
- load data_in=16'h12AF mid-frame -> old data held until index wraps to 0; then digit 0 shows seg for F (active-low 7'b0111000) and digit 3 shows 1 (7'b1001111).
- lz_suppress=1, data_in=16'h0050 -> digits 3 and 2 dark, digit 1 shows 5, digit 0 shows 0; data 16'h0000 -> only digit 0 lit, showing 0.
- dp_in=4'b0100, blank_in=4'b0001 -> dp active only while an selects digit 2; digit 0 an stays inactive.
- load coincident with the wrap tick, followed by a second load 2 cycles later -> first value shown for a full frame, second value from the next frame.
- Reset asserted mid-scan while a pending load is outstanding -> next cycle an all inactive and index 0; pending data discarded, shadow = 0.
